// File: rtl/icap_reg_reader_pkg.sv
// ICAP register readback: shared state encodings and config words.
// Also reused by the multiboot writer (sync/NOOP/CMD/DESYNC, type-1 fields).
package icap_reg_reader_pkg;

  typedef enum logic [3:0] {
    IDLE, DUMMY, SYNC_H, SYNC_L,
    NOOP_A, RD_HDR, NOOP_B, NOOP_C,
    RD_TURN, RD_WAIT, RD_END, WR_TURN,
    CMD_HDR, DESYNC, NOOP_D, NOOP_E
  } state_e;

  localparam logic [15:0] W_IDLE    = 16'hFFFF;
  localparam logic [15:0] W_DUMMY   = 16'hFFFF;
  localparam logic [15:0] W_SYNC_H  = 16'hAA99;
  localparam logic [15:0] W_SYNC_L  = 16'h5566;
  localparam logic [15:0] W_NOOP    = 16'h2000;
  localparam logic [15:0] W_CMD_HDR = 16'h30A1;
  localparam logic [15:0] W_DESYNC  = 16'h000D;

  // type-1 packet header fields
  localparam logic [15:0] T1_TYPE   = 16'h2000;
  localparam logic [15:0] T1_OP_RD  = 16'h0800;
  localparam logic [15:0] T1_WC_1   = 16'h0001;
  localparam int          T1_ADDR_LSB = 5;

  function automatic logic [15:0] t1_rd_hdr(
    input logic [5:0] addr
  );
    logic [15:0] a;
    a = {10'd0, addr} << T1_ADDR_LSB;
    return T1_TYPE | T1_OP_RD | T1_WC_1 | a;
  endfunction

endpackage

// File: rtl/icap_reg_reader_if.sv
// ICAP_SPARTAN6 port bundle (CE, WRITE, I, O, BUSY).
// master: reader driving the ICAP; slave: the ICAP primitive or its model.
interface icap_reg_reader_if;
  logic        icap_ce;
  logic        icap_wr;
  logic [15:0] icap_i;
  logic [15:0] icap_o;
  logic        icap_busy;

  modport master (
    output icap_ce, icap_wr, icap_i,
    input  icap_o, icap_busy
  );

  modport slave (
    input  icap_ce, icap_wr, icap_i,
    output icap_o, icap_busy
  );
endinterface

// File: rtl/icap_bitswap.sv
// Bit reversal within each byte of a 16-bit word (ICAP bit order).
// din_i: natural order word; dout_o: byte-wise reversed word.
module icap_bitswap (
  input  logic [15:0] din_i,
  output logic [15:0] dout_o
);
  for (genvar b = 0; b < 8; b++) begin : g_bit
    assign dout_o[7-b]  = din_i[b];
    assign dout_o[15-b] = din_i[8+b];
  end
endmodule

// File: rtl/icap_reg_reader.sv
// Reads one configuration register through ICAP_SPARTAN6 and desyncs.
// Ports: clk/reset, start/reg_addr request, busy/done/error/data_out, icap bus.
module icap_reg_reader
  import icap_reg_reader_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         reg_addr,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        data_out,
  icap_reg_reader_if.master  icap
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic [15:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ce_q, ce_d;
  logic          wr_q, wr_d;
  logic [15:0]   i_q, i_d;
  logic [15:0]   word_d;
  logic          obusy_q;
  logic [15:0]   o_q, o_sw;

  icap_bitswap u_wr_swap (.din_i(word_d), .dout_o(i_d));
  icap_bitswap u_rd_swap (.din_i(o_q),    .dout_o(o_sw));

  // next state, latched request and readback result
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = '0;
    err_d   = err_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DUMMY;
          addr_d  = reg_addr;
          err_d   = 1'b0;
        end
      end
      RD_WAIT: begin
        wcnt_d = wcnt_q + CW'(1);
        // O/BUSY are retimed, so wcnt_q==k sees wait cycle k;
        // the first wait cycle is never trusted
        if (wcnt_q > CW'(1) && !obusy_q) begin
          data_d  = o_sw;
          state_d = RD_END;
        end else if (wcnt_q == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = RD_END;
        end
      end
      NOOP_E:  state_d = IDLE;
      default: state_d = state_e'(state_q + 4'd1);
    endcase
  end

  // ICAP controls follow the state being entered
  always_comb begin
    ce_d   = 1'b1;
    wr_d   = 1'b1;
    word_d = W_IDLE;
    unique case (state_d)
      DUMMY:   begin ce_d = 1'b0; wr_d = 1'b0; word_d = W_DUMMY;   end
      SYNC_H:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = W_SYNC_H;  end
      SYNC_L:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = W_SYNC_L;  end
      RD_HDR:  begin
        ce_d   = 1'b0;
        wr_d   = 1'b0;
        word_d = t1_rd_hdr(addr_q);
      end
      NOOP_A, NOOP_B, NOOP_C, NOOP_D, NOOP_E: begin
        ce_d   = 1'b0;
        wr_d   = 1'b0;
        word_d = W_NOOP;
      end
      CMD_HDR: begin ce_d = 1'b0; wr_d = 1'b0; word_d = W_CMD_HDR; end
      DESYNC:  begin ce_d = 1'b0; wr_d = 1'b0; word_d = W_DESYNC;  end
      RD_WAIT: ce_d = 1'b0;
      WR_TURN: wr_d = 1'b0;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == NOOP_E);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_q    <= 1'b1;
      wr_q    <= 1'b1;
      i_q     <= 16'hFFFF;
      obusy_q <= 1'b1;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ce_q    <= ce_d;
      wr_q    <= wr_d;
      i_q     <= i_d;
      obusy_q <= icap.icap_busy;
      o_q     <= icap.icap_o;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign data_out     = data_q;
  assign icap.icap_ce = ce_q;
  assign icap.icap_wr = wr_q;
  assign icap.icap_i  = i_q;

endmodule

// File: doc/icap_reg_reader.md
ICAP_REG_READER -- requirements
Module: icap_reg_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum RD_WAIT cycles with icap_busy high before abort.
REQ-002 SHALL have port clk, input, 1: single clock, also drives the ICAP_SPARTAN6 CLK at top level.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: request one register readback; honoured only in IDLE.
REQ-005 SHALL have port reg_addr, input, 6: configuration register address, latched when start is accepted.
REQ-006 SHALL have port busy, output, 1: high from the cycle after acceptance until done.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when the sequence completes.
REQ-008 SHALL have port error, output, 1: valid with done; high when the read timed out.
REQ-009 SHALL have port data_out, output, 16: last register value read, in natural bit order.
REQ-010 SHALL have port icap_ce, output, 1: ICAP CE, active-low, registered.
REQ-011 SHALL have port icap_wr, output, 1: ICAP WRITE, 0 = write, 1 = read, registered.
REQ-012 SHALL have port icap_i, output, 16: ICAP I, bit-swapped within each byte, registered.
REQ-013 SHALL have port icap_o, input, 16: ICAP O, bit-swapped within each byte.
REQ-014 SHALL have port icap_busy, input, 1: ICAP BUSY.

Function
REQ-015 The FSM SHALL use these states in order: IDLE, DUMMY, SYNC_H, SYNC_L, NOOP_A, RD_HDR, NOOP_B, NOOP_C, RD_TURN, RD_WAIT, RD_END, WR_TURN, CMD_HDR, DESYNC, NOOP_D, NOOP_E, then back to IDLE.
REQ-016 Each non-wait state SHALL last exactly one cycle; icap_* outputs SHALL be registered from the state entered.
REQ-017 Write words (CE=0, WR=0) SHALL be:
- DUMMY 0xFFFF, SYNC_H 0xAA99, SYNC_L 0x5566
- NOOP_A/B/C/D/E 0x2000
- RD_HDR 0x2801 | (reg_addr << 5), i.e. a type-1 read of one word
- CMD_HDR 0x30A1, DESYNC 0x000D
REQ-018 CE/WR per state SHALL be:
- RD_TURN: CE=1, WR=1
- RD_WAIT: CE=0, WR=1
- RD_END: CE=1, WR=1
- WR_TURN: CE=1, WR=0
- IDLE: CE=1, WR=1, icap_i=0xFFFF
REQ-019 In RD_WAIT the first cycle SHALL be ignored; on any later cycle with icap_busy=0, data_out SHALL load bitswap(icap_o) and the FSM SHALL go to RD_END.
REQ-020 If icap_busy stays high for TIMEOUT RD_WAIT cycles, the FSM SHALL set error, leave data_out unchanged and go to RD_END; the desync sequence SHALL always complete.
REQ-021 done SHALL pulse on the cycle IDLE is re-entered; with minimum wait this is 17 edges after the edge sampling start.
REQ-022 start while busy SHALL be ignored; start held high in IDLE after done SHALL begin a new sequence.
REQ-023 error SHALL clear on the next accepted start.

Reset
REQ-024 Asynchronous reset SHALL force: state=IDLE, icap_ce=1, icap_wr=1, icap_i=0xFFFF, busy=0, done=0, error=0, data_out=0x0000, timeout counter=0.
REQ-025 Reset mid-sequence SHALL abandon the sequence without any desync or done pulse.

Structure
REQ-026 Shared header icap_defs SHALL hold the state encodings, the sync/NOOP/CMD/DESYNC words and the type-1 header field constants, for reuse by the multiboot writer.
REQ-027 Sub-module icap_bitswap (byte-wise bit reversal) SHALL be instantiated twice, on the write path and the read path.

Verification
REQ-028 reg_addr=0x14 with model O=0xC0A0 and busy low on the 2nd RD_WAIT cycle -> icap_i sequence FFFF, AA99, 5566, 2000, 2A81, ... (pre-swap), data_out=0x0305, error=0, done at edge 17.
REQ-029 reg_addr=0x16 with busy high for 10 wait cycles -> header 0x2AC1, done at edge 26, data_out = swapped O.
REQ-030 busy stuck high -> error=1 after TIMEOUT cycles, data_out unchanged, CMD_HDR/DESYNC still emitted.
REQ-031 start pulsed during RD_WAIT -> ignored, single done pulse.
REQ-032 reset asserted in SYNC_L -> outputs at reset values immediately, no done; next start restarts from DUMMY.
